// File: rtl/continuous_monitoring_system_pkg.sv
`default_nettype none
// ============================================================================
// Module   : continuous_monitoring_system_pkg
// Brief    : Shared types for the continuous monitoring system, including the
//            trace filter rule format and filter controller state encoding.
// Revision : 1.0 - initial trace filter controller additions
// ============================================================================
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;

  // Action applied to a trace entry when a rule (or the default) selects it
  typedef enum logic [0:0] {
    ACT_KEEP = 1'b0,
    ACT_DROP = 1'b1
  } filter_action_e;

  // Rule table controller: RUN accepts writes, COPY moves shadow to active
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    COPY = 1'b1
  } filter_ctrl_state_e;

  typedef struct packed {
    logic                                en;
    filter_action_e                      action;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] mask;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] match;
  } rule_t;

  // A rule hits when enabled and the masked instruction equals its match value
  function automatic logic rule_hits(input rule_t rule,
                                     input logic [RISC_V_INSTRUCTION_WIDTH-1:0] word);
    return rule.en && ((word & rule.mask) == rule.match);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trace_filter_rule_match.sv
`default_nettype none
// ============================================================================
// Module   : trace_filter_rule_match
// Brief    : Combinational priority matcher over the active rule table. The
//            lowest-index hitting rule decides; otherwise the default applies.
// Revision : 1.0 - initial release
// ============================================================================
module trace_filter_rule_match
  import continuous_monitoring_system_pkg::*;
#(
  parameter int NUM_RULES = 8
) (
  input  rule_t [NUM_RULES-1:0]                rules,
  input  filter_action_e                       default_action,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0]  instr,
  output logic                                 hit,
  output logic [$clog2(NUM_RULES)-1:0]         hit_index,
  output filter_action_e                       action
);

  localparam int IDX_W = $clog2(NUM_RULES);

  logic [NUM_RULES-1:0] w_hit_vec;

  // Each rule compares independently; priority is resolved below
  generate
    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule_hit
      assign w_hit_vec[g] = rule_hits(rules[g], instr);
    end
  endgenerate

  // Scan from the highest index down so the lowest hitting index wins last
  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    action    = default_action;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        hit       = 1'b1;
        hit_index = IDX_W'(i);
        action    = rules[i].action;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/trace_filter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trace_filter_ctrl
// Brief    : Trace filter controller. Double-buffered mask/match rule table
//            with atomic commit, 1-cycle per-instruction drop decision and
//            saturating drop/pass statistics.
// Revision : 1.0 - initial release
// ============================================================================
module trace_filter_ctrl
  import continuous_monitoring_system_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [$clog2(NUM_RULES)-1:0]        cfg_addr,
  input  rule_t                               cfg_rule,
  input  logic                                cfg_default_action,
  input  logic                                commit,
  output logic                                commit_done,
  input  logic                                instr_valid,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
  output logic                                drop_valid,
  output logic                                drop_instr,
  output logic [CNT_WIDTH-1:0]                drop_count,
  output logic [CNT_WIDTH-1:0]                pass_count,
  input  logic                                cnt_clear
);

  localparam int IDX_W = $clog2(NUM_RULES);

  filter_ctrl_state_e          r_state;
  filter_ctrl_state_e          w_state_next;
  logic                        w_copy_en;
  logic                        w_cfg_fire;

  rule_t [NUM_RULES-1:0]       r_shadow;
  rule_t [NUM_RULES-1:0]       r_active;
  filter_action_e              r_default;

  logic                        r_commit_done;
  logic                        r_drop_valid;
  logic                        r_drop_instr;
  logic [CNT_WIDTH-1:0]        r_drop_count;
  logic [CNT_WIDTH-1:0]        r_pass_count;

  logic                        w_match_hit;
  logic [IDX_W-1:0]            w_match_index;
  filter_action_e              w_match_action;
  logic                        w_is_drop;
  logic                        w_unused_match_info;

  trace_filter_rule_match #(
    .NUM_RULES (NUM_RULES)
  ) u_rule_match (
    .rules          (r_active),
    .default_action (r_default),
    .instr          (instr),
    .hit            (w_match_hit),
    .hit_index      (w_match_index),
    .action         (w_match_action)
  );

  // Hit details are informational only; the decision uses the resolved action
  assign w_unused_match_info = ^{w_match_hit, w_match_index};

  assign w_cfg_fire = cfg_valid && cfg_ready;
  assign w_is_drop  = enable && (w_match_action == ACT_DROP);

  // State register for the commit sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode; commits arriving during COPY are dropped
  always_comb begin
    w_state_next = r_state;
    w_copy_en    = 1'b0;
    cfg_ready    = 1'b0;
    unique case (r_state)
      RUN: begin
        cfg_ready = 1'b1;
        if (commit) begin
          w_state_next = COPY;
        end
      end
      COPY: begin
        w_copy_en    = 1'b1;
        w_state_next = RUN;
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  // Rule banks: writes land in shadow, active only changes in the COPY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_default <= ACT_KEEP;
    end else begin
      if (w_cfg_fire) begin
        r_shadow[cfg_addr] <= cfg_rule;
      end
      if (w_copy_en) begin
        r_active  <= r_shadow;
        r_default <= filter_action_e'(cfg_default_action);
      end
    end
  end

  // Completion pulse follows the COPY cycle by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit_done <= 1'b0;
    end else begin
      r_commit_done <= w_copy_en;
    end
  end

  // Result register: one result per sampled instruction, no backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_valid <= 1'b0;
      r_drop_instr <= 1'b0;
    end else begin
      r_drop_valid <= instr_valid;
      r_drop_instr <= instr_valid && w_is_drop;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      r_drop_count <= '0;
      r_pass_count <= '0;
    end else if (instr_valid && enable) begin
      if (w_match_action == ACT_DROP) begin
        if (!(&r_drop_count)) begin
          r_drop_count <= r_drop_count + CNT_WIDTH'(1);
        end
      end else begin
        if (!(&r_pass_count)) begin
          r_pass_count <= r_pass_count + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign commit_done = r_commit_done;
  assign drop_valid  = r_drop_valid;
  assign drop_instr  = r_drop_instr;
  assign drop_count  = r_drop_count;
  assign pass_count  = r_pass_count;

endmodule
`default_nettype wire
